ub_read_arbiter: RTL and testbench
==================================

// Module: ub_read_arbiter
//
// PURPOSE
// Shares the single unified_buffer read port between NUM_REQ requesters, e.g. the
// input-activation loader and the weight loader. Arbitration is round-robin. The
// block accepts one read command (addr, len, transpose) per grant, bounds-checks it
// and issues a one-cycle read start to the buffer. It holds the transpose select
// stable for the whole burst and counts returned valid elements to detect completion.
// It sits between the instruction decode/requesters and unified_buffer.
//
// PARAMETERS
// NUM_REQ    2    number of requesters (legal range 2..4)
// ADDR_W     6    buffer address width; matches the buffer read address port
// LEN_W      6    command length width; matches the buffer location-count port
// UB_DEPTH   50   buffer depth; a command needs addr+len <= UB_DEPTH
// TIMEOUT    255  maximum WAIT cycles before the burst is abandoned (8-bit counter)
//
// PORTS
// clk                 in   1               clock, rising edge
// rst                 in   1               async reset, active-high
// req_valid_in        in   NUM_REQ         per-requester command valid; held until ready
// req_ready_out       out  NUM_REQ         one-hot accept pulse (comb., IDLE state only)
// req_addr_in         in   NUM_REQ*ADDR_W  start address; requester i at [i*ADDR_W +: ADDR_W]
// req_len_in          in   NUM_REQ*LEN_W   element count; requester i at [i*LEN_W +: LEN_W]
// req_transpose_in    in   NUM_REQ         transpose select per requester
// ub_read_start_out   out  1               one-cycle read start to the buffer
// ub_read_addr_out    out  ADDR_W          latched address; stable from ISSUE through WAIT
// ub_num_locs_out     out  LEN_W           latched length; stable from ISSUE through WAIT
// ub_transpose_out    out  1               latched transpose; stable from ISSUE through WAIT
// ub_valid_1_in       in   1               buffer output valid, lane 1
// ub_valid_2_in       in   1               buffer output valid, lane 2
// grant_id_out        out  2               index of the owner of the current/last burst
// busy_out            out  1               high in ISSUE, WAIT and DONE
// done_out            out  NUM_REQ         one-hot, one-cycle pulse on successful completion
// err_out             out  NUM_REQ         one-hot, one-cycle pulse on reject or timeout
//
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; rr pointer = NUM_REQ-1, so requester 0 has
//   priority first; counters 0. Reset mid-burst aborts the burst with no done/err
//   pulse; the buffer shares rst.
// - IDLE
//   - With any req_valid_in set, the winner is the first set bit searching upward
//     (with wrap) from rr_ptr+1.
//   - The winner gets req_ready_out asserted in that cycle. At the clock edge the
//     block latches addr, len and transpose, sets grant_id and sets rr_ptr = winner.
//   - Next state is ERR if len==0 or addr+len > UB_DEPTH, otherwise ISSUE.
//   - The addr+len sum is computed at ADDR_W+1 bits, so there is no wrap.
// - ISSUE (1 cycle): ub_read_start_out=1; clear rx_cnt (LEN_W+1 bits) and the timeout
//   counter; go to WAIT.
// - WAIT
//   - Each cycle rx_cnt += ub_valid_1_in + ub_valid_2_in; both lanes high adds 2.
//   - When rx_cnt plus this cycle's increment >= len, go to DONE.
//   - An overshoot (count beyond len) is treated as completion.
//   - If the timeout counter reaches TIMEOUT first, go to ERR.
//   - Expected response: first element 1 cycle after ISSUE, then pairs, last
//     element single; total valid elements = len.
// - DONE (1 cycle): done_out[grant_id]=1; go to IDLE. The earliest next start is
//   2 cycles after the last valid, which guarantees the buffer is idle again.
// - ERR (1 cycle): err_out[grant_id]=1; no start issued (reject) or burst abandoned
//   (timeout); go to IDLE.
// - Requests arriving while busy wait. req_ready_out is 0 outside IDLE. Requesters
//   must not drop req_valid_in before ready.
// - Simultaneous requests always resolve by round-robin order. No requester can be
//   starved: it waits at most NUM_REQ-1 bursts.
// - ub_valid_* seen outside WAIT are ignored.
// - Throughput: len=N takes 1 (IDLE) + 1 (ISSUE) + about N/2+1 (WAIT) + 1 (DONE)
//   cycles.
//
// TESTING
// - Reset: assert rst mid-WAIT -> all outputs 0 next cycle, state IDLE; then req1
//   and req0 valid -> req0 granted first.
// - Single read: req0 addr=4, len=6, transpose=1 -> one start pulse, addr=4,
//   num_locs=6, transpose held 1. Buffer model returns 1+2+2+1 valids, then
//   done_out=01 exactly once.
// - Round-robin: req0 and req1 continuously valid with len=2 -> grant order
//   0,1,0,1; each done_out pulse matches grant_id.
// - Rejects:
//   - addr=48, len=4 (52 > 50) -> err_out pulse, no start.
//   - len=0 -> err_out pulse, no start.
//   - addr=46, len=4 -> accepted.
// - Timeout: buffer model never asserts valid -> err_out after 255 WAIT cycles,
//   then a new grant proceeds normally.
// - Odd length: len=3 -> valids 1 then 2 -> done after rx_cnt=3. Inject a stray
//   valid in IDLE -> no effect.

Source files
------------

// File: rtl/ub_read_arbiter_if.sv
// Bundle between the requesters/unified_buffer side and ub_read_arbiter.
// The arbiter connects through the slave modport; the surrounding logic
// (decode, loaders, buffer) drives the master side.
interface ub_read_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned LEN_W   = 6
);
    logic [NUM_REQ-1:0]        req_valid_in;
    logic [NUM_REQ-1:0]        req_ready_out;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_in;
    logic [NUM_REQ*LEN_W-1:0]  req_len_in;
    logic [NUM_REQ-1:0]        req_transpose_in;
    logic                      ub_read_start_out;
    logic [ADDR_W-1:0]         ub_read_addr_out;
    logic [LEN_W-1:0]          ub_num_locs_out;
    logic                      ub_transpose_out;
    logic                      ub_valid_1_in;
    logic                      ub_valid_2_in;
    logic [1:0]                grant_id_out;
    logic                      busy_out;
    logic [NUM_REQ-1:0]        done_out;
    logic [NUM_REQ-1:0]        err_out;

    modport slave (
        input  req_valid_in, req_addr_in, req_len_in, req_transpose_in,
        input  ub_valid_1_in, ub_valid_2_in,
        output req_ready_out, ub_read_start_out, ub_read_addr_out,
        output ub_num_locs_out, ub_transpose_out, grant_id_out,
        output busy_out, done_out, err_out
    );

    modport master (
        output req_valid_in, req_addr_in, req_len_in, req_transpose_in,
        output ub_valid_1_in, ub_valid_2_in,
        input  req_ready_out, ub_read_start_out, ub_read_addr_out,
        input  ub_num_locs_out, ub_transpose_out, grant_id_out,
        input  busy_out, done_out, err_out
    );
endinterface

// File: rtl/ub_read_arbiter.sv
// Round-robin arbiter for the single unified_buffer read port. Accepts one
// bounds-checked read command per grant, pulses a read start, holds the
// command fields for the burst and counts returned elements (with timeout).
module ub_read_arbiter #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned LEN_W    = 6,
    parameter int unsigned UB_DEPTH = 50,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    ub_read_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          rr_q, rr_d;
    logic [1:0]          grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                tr_q, tr_d;
    logic [LEN_W:0]      rx_q, rx_d;
    logic [7:0]          tmo_q, tmo_d;

    logic                win_found;
    logic [1:0]          win_idx;
    logic [1:0]          cand;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LEN_W-1:0]    sel_len;
    logic                sel_tr;
    logic [ADDR_W:0]     end_sum;
    logic [LEN_W:0]      rx_sum;
    logic [NUM_REQ-1:0]  ready;
    logic [NUM_REQ-1:0]  done;
    logic [NUM_REQ-1:0]  err;
    logic                start;

    // Round-robin winner: first valid requester searching upward from rr_q+1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 2'((32'(rr_q) + k) % NUM_REQ);
            if (!win_found && (|(bus.req_valid_in & (NUM_REQ'(1) << cand)))) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign sel_addr = bus.req_addr_in[32'(win_idx) * ADDR_W +: ADDR_W];
    assign sel_len  = bus.req_len_in[32'(win_idx) * LEN_W +: LEN_W];
    assign sel_tr   = |(bus.req_transpose_in & (NUM_REQ'(1) << win_idx));
    assign end_sum  = {1'b0, sel_addr} + (ADDR_W+1)'(sel_len);
    assign rx_sum   = rx_q + (LEN_W+1)'(bus.ub_valid_1_in) + (LEN_W+1)'(bus.ub_valid_2_in);

    // State and command registers; reset aborts any burst silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= 2'(NUM_REQ - 1);
            grant_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            tr_q    <= 1'b0;
            rx_q    <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            tr_q    <= tr_d;
            rx_q    <= rx_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and per-state outputs of the grant/issue/wait sequence.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        len_d   = len_q;
        tr_d    = tr_q;
        rx_d    = rx_q;
        tmo_d   = tmo_q;
        ready   = '0;
        done    = '0;
        err     = '0;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    ready   = NUM_REQ'(1) << win_idx;
                    addr_d  = sel_addr;
                    len_d   = sel_len;
                    tr_d    = sel_tr;
                    grant_d = win_idx;
                    rr_d    = win_idx;
                    if (sel_len == '0 || end_sum > (ADDR_W+1)'(UB_DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                start   = 1'b1;
                rx_d    = '0;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                rx_d = rx_sum;
                // Completion wins over timeout when both occur in the same cycle.
                if (rx_sum >= {1'b0, len_q}) begin
                    state_d = S_DONE;
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DONE: begin
                done    = NUM_REQ'(1) << grant_q;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err     = NUM_REQ'(1) << grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready_out     = ready;
    assign bus.ub_read_start_out = start;
    assign bus.ub_read_addr_out  = addr_q;
    assign bus.ub_num_locs_out   = len_q;
    assign bus.ub_transpose_out  = tr_q;
    assign bus.grant_id_out      = grant_q;
    assign bus.busy_out          = (state_q != S_IDLE);
    assign bus.done_out          = done;
    assign bus.err_out           = err;
endmodule

// File: tb/tb_ub_read_arbiter.sv
// Directed bench for ub_read_arbiter: reset, single burst, reset abort,
// round-robin ordering, bounds rejects, timeout, odd length and stray valids.
module tb_ub_read_arbiter;
    localparam int unsigned NR = 2;
    localparam int unsigned AW = 6;
    localparam int unsigned LW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*AW-1:0] req_addr  = '0;
    logic [NR*LW-1:0] req_len   = '0;
    logic [NR-1:0]    req_tr    = '0;
    logic m_v1 = 1'b0;
    logic m_v2 = 1'b0;
    logic stray_v1 = 1'b0;
    bit   buf_en = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n     = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int end_cyc   = 0;
    int done_cnt[NR] = '{default: 0};
    int err_cnt[NR]  = '{default: 0};
    int grant_log[$];

    ub_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW)) bus();

    ub_read_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW), .UB_DEPTH(50), .TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.req_valid_in     = req_valid;
    assign bus.req_addr_in      = req_addr;
    assign bus.req_len_in       = req_len;
    assign bus.req_transpose_in = req_tr;
    assign bus.ub_valid_1_in    = m_v1 | stray_v1;
    assign bus.ub_valid_2_in    = m_v2;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Present a command on requester r and hold it until accepted.
    task automatic request(input int r, input int a, input int l, input int t);
        int n = 0;
        req_addr[r*AW +: AW] = AW'(a);
        req_len[r*LW +: LW]  = LW'(l);
        req_tr[r]            = t[0];
        req_valid[r]         = 1'b1;
        #1;
        while (!bus.req_ready_out[r] && n < 50) begin
            cyc(1);
            n++;
        end
        chk("ready_seen", int'(bus.req_ready_out[r]), 1);
        cyc(1);
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (bus.busy_out && n < max) begin
            cyc(1);
            n++;
        end
        chk("idle_reached", int'(bus.busy_out), 0);
    endtask

    // Event monitor: start/done/err pulses and grants, one sample per cycle.
    always @(negedge clk) begin
        cyc_n++;
        if (!rst) begin
            if (bus.ub_read_start_out) begin
                start_cnt++;
                start_cyc = cyc_n;
            end
            if (|bus.req_ready_out) grant_log.push_back(bus.req_ready_out[1] ? 1 : 0);
            if (|bus.done_out) begin
                end_cyc = cyc_n;
                for (int i = 0; i < NR; i++) if (bus.done_out[i]) done_cnt[i]++;
                chk("done_matches_grant", int'(bus.done_out), 1 << bus.grant_id_out);
            end
            if (|bus.err_out) begin
                end_cyc = cyc_n;
                for (int i = 0; i < NR; i++) if (bus.err_out[i]) err_cnt[i]++;
                chk("err_matches_grant", int'(bus.err_out), 1 << bus.grant_id_out);
            end
        end
    end

    // Buffer model: first element one cycle after start, then pairs, last single.
    initial begin : buf_model
        int rem;
        forever begin
            @(negedge clk);
            if (buf_en && !rst && bus.ub_read_start_out) begin
                rem = int'(bus.ub_num_locs_out);
                @(negedge clk);
                m_v1 = 1'b1;
                m_v2 = 1'b0;
                rem--;
                while (rem > 0 && !rst) begin
                    @(negedge clk);
                    if (rem >= 2) begin
                        m_v1 = 1'b1;
                        m_v2 = 1'b1;
                        rem -= 2;
                    end else begin
                        m_v1 = 1'b1;
                        m_v2 = 1'b0;
                        rem = 0;
                    end
                end
                @(negedge clk);
                m_v1 = 1'b0;
                m_v2 = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin : main
        int s0, d0, d1, e0, e1;

        // Reset state
        cyc(2);
        chk("rst_busy", int'(bus.busy_out), 0);
        chk("rst_start", int'(bus.ub_read_start_out), 0);
        chk("rst_ready", int'(bus.req_ready_out), 0);
        chk("rst_done", int'(bus.done_out), 0);
        chk("rst_err", int'(bus.err_out), 0);
        chk("rst_grant", int'(bus.grant_id_out), 0);
        chk("rst_addr", int'(bus.ub_read_addr_out), 0);
        chk("rst_len", int'(bus.ub_num_locs_out), 0);
        rst = 1'b0;
        cyc(1);

        // Single read: addr 4, len 6, transpose 1
        request(0, 4, 6, 1);
        chk("single_start", int'(bus.ub_read_start_out), 1);
        chk("single_addr", int'(bus.ub_read_addr_out), 4);
        chk("single_len", int'(bus.ub_num_locs_out), 6);
        chk("single_tr", int'(bus.ub_transpose_out), 1);
        chk("single_grant", int'(bus.grant_id_out), 0);
        cyc(2);
        chk("single_start_once", int'(bus.ub_read_start_out), 0);
        chk("single_tr_held", int'(bus.ub_transpose_out), 1);
        chk("single_addr_held", int'(bus.ub_read_addr_out), 4);
        wait_idle(50);
        chk("single_done_cnt", done_cnt[0], 1);
        chk("single_start_cnt", start_cnt, 1);
        chk("single_err_cnt", err_cnt[0] + err_cnt[1], 0);
        chk("single_latency", end_cyc - start_cyc, 5);

        // Reset mid-WAIT aborts with no pulse
        request(0, 0, 6, 1);
        cyc(2);
        chk("abort_in_wait", int'(bus.busy_out), 1);
        d0 = done_cnt[0] + done_cnt[1];
        e0 = err_cnt[0] + err_cnt[1];
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(bus.busy_out), 0);
        chk("abort_addr", int'(bus.ub_read_addr_out), 0);
        chk("abort_len", int'(bus.ub_num_locs_out), 0);
        chk("abort_tr", int'(bus.ub_transpose_out), 0);
        chk("abort_done", int'(bus.done_out), 0);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        chk("abort_no_done", done_cnt[0] + done_cnt[1], d0);
        chk("abort_no_err", err_cnt[0] + err_cnt[1], e0);
        chk("abort_idle", int'(bus.busy_out), 0);

        // Round-robin with both requesters continuously valid
        grant_log.delete();
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        req_addr  = {6'd10, 6'd0};
        req_len   = {6'd2, 6'd2};
        req_tr    = '0;
        req_valid = 2'b11;
        begin
            int n = 0;
            while (grant_log.size() < 4 && n < 200) begin
                cyc(1);
                n++;
            end
        end
        req_valid = '0;
        chk("rr_grants", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            chk("rr_g0", grant_log[0], 0);
            chk("rr_g1", grant_log[1], 1);
            chk("rr_g2", grant_log[2], 0);
            chk("rr_g3", grant_log[3], 1);
        end
        wait_idle(50);
        chk("rr_done0", done_cnt[0] - d0, 2);
        chk("rr_done1", done_cnt[1] - d1, 2);

        // Reject: 48+4 exceeds depth
        s0 = start_cnt;
        e1 = err_cnt[1];
        request(1, 48, 4, 0);
        chk("rej_over_start", int'(bus.ub_read_start_out), 0);
        chk("rej_over_err", int'(bus.err_out), 2);
        wait_idle(10);
        chk("rej_over_errcnt", err_cnt[1] - e1, 1);
        chk("rej_over_nostart", start_cnt, s0);

        // Reject: zero length
        e0 = err_cnt[0];
        request(0, 10, 0, 0);
        chk("rej_zero_err", int'(bus.err_out), 1);
        wait_idle(10);
        chk("rej_zero_errcnt", err_cnt[0] - e0, 1);
        chk("rej_zero_nostart", start_cnt, s0);

        // Accept at the exact depth boundary: 46+4 == 50
        d1 = done_cnt[1];
        request(1, 46, 4, 1);
        chk("edge_start", int'(bus.ub_read_start_out), 1);
        chk("edge_noerr", int'(bus.err_out), 0);
        wait_idle(50);
        chk("edge_done", done_cnt[1] - d1, 1);

        // Timeout with a silent buffer, then a normal burst
        buf_en = 1'b0;
        e0 = err_cnt[0];
        d0 = done_cnt[0];
        request(0, 0, 2, 0);
        chk("tmo_start", int'(bus.ub_read_start_out), 1);
        wait_idle(300);
        chk("tmo_err", err_cnt[0] - e0, 1);
        chk("tmo_nodone", done_cnt[0], d0);
        chk("tmo_cycles", end_cyc - start_cyc, 256);
        buf_en = 1'b1;
        d1 = done_cnt[1];
        request(1, 20, 4, 0);
        wait_idle(50);
        chk("after_tmo_done", done_cnt[1] - d1, 1);
        chk("after_tmo_latency", end_cyc - start_cyc, 4);

        // Odd length: 1 then 2
        d0 = done_cnt[0];
        request(0, 5, 3, 1);
        wait_idle(50);
        chk("odd_done", done_cnt[0] - d0, 1);
        chk("odd_latency", end_cyc - start_cyc, 3);

        // Stray valid while idle has no effect
        s0 = start_cnt;
        d0 = done_cnt[0] + done_cnt[1];
        stray_v1 = 1'b1;
        cyc(3);
        chk("stray_busy", int'(bus.busy_out), 0);
        chk("stray_nostart", start_cnt, s0);
        chk("stray_nodone", done_cnt[0] + done_cnt[1], d0);
        stray_v1 = 1'b0;
        d1 = done_cnt[1];
        request(1, 0, 2, 0);
        wait_idle(50);
        chk("post_stray_done", done_cnt[1] - d1, 1);
        chk("post_stray_latency", end_cyc - start_cyc, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
